// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, opcode encodings, arbiter FSM states.
// Zero latency (constants and types only); no handshake of its own.
package alu_pkg;
    localparam int ALU_WIDTH = 16;

    localparam logic [2:0] ALU_OP_ADD = 3'b000;
    localparam logic [2:0] ALU_OP_SUB = 3'b001;
    localparam logic [2:0] ALU_OP_SLL = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } alu_arb_state_t;

    function automatic logic alu_op_legal(input logic [2:0] op);
        return (op == ALU_OP_ADD) || (op == ALU_OP_SUB) || (op == ALU_OP_SLL);
    endfunction
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, one-hot, purely combinational (zero latency).
// No backpressure: the caller qualifies the grant with its own readiness.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);
    // On contention the requester that did not win last time goes next.
    always_comb begin
        grant = 2'b00;
        if (valid[0] && (!valid[1] || last_grant))
            grant[0] = 1'b1;
        if (valid[1] && (!valid[0] || !last_grant))
            grant[1] = 1'b1;
    end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sequencer for the shared ALU: request in cycle 0, ALU cycle 1, response from cycle 2.
// Response backpressure stalls the block in RESP; ALU_ARB_OP_CHECK_EN adds illegal-opcode reporting on rsp_err.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
`ifdef ALU_ARB_OP_CHECK_EN
    output logic             rsp_err,
`endif
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             busy
);
    alu_arb_state_t   state;
    logic             last_grant;
    logic             owner;
    logic [WIDTH-1:0] a_q, b_q, result_q;
    logic [2:0]       op_q;
    logic             zero_q;
    logic [1:0]       grant;
    logic             take;
    logic             rsp_take;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [2:0]       sel_op;
`ifdef ALU_ARB_OP_CHECK_EN
    logic             ill_q;
    logic             err_q;
`endif

    rr_arb2 u_rr_arb2 (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign req0_ready = (state == ST_IDLE) && grant[0];
    assign req1_ready = (state == ST_IDLE) && grant[1];
    assign take       = req0_ready || req1_ready;

    assign sel_a  = grant[1] ? req1_a  : req0_a;
    assign sel_b  = grant[1] ? req1_b  : req0_b;
    assign sel_op = grant[1] ? req1_op : req0_op;

    assign rsp_take   = owner ? rsp1_ready : rsp0_ready;
    assign rsp0_valid = (state == ST_RESP) && !owner;
    assign rsp1_valid = (state == ST_RESP) && owner;
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_control = op_q;
    assign busy        = (state != ST_IDLE);
`ifdef ALU_ARB_OP_CHECK_EN
    assign rsp_err = err_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= ALU_OP_ADD;
            result_q   <= '0;
            zero_q     <= 1'b0;
`ifdef ALU_ARB_OP_CHECK_EN
            ill_q      <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        owner      <= grant[1];
                        last_grant <= grant[1];
                        a_q        <= sel_a;
                        b_q        <= sel_b;
`ifdef ALU_ARB_OP_CHECK_EN
                        // Illegal opcodes still spend the ALU cycle, but as a harmless add.
                        op_q       <= alu_op_legal(sel_op) ? sel_op : ALU_OP_ADD;
                        ill_q      <= !alu_op_legal(sel_op);
`else
                        op_q       <= sel_op;
`endif
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
`ifdef ALU_ARB_OP_CHECK_EN
                    result_q <= ill_q ? '0 : alu_result;
                    zero_q   <= ill_q ? 1'b0 : alu_zero;
                    err_q    <= ill_q;
`else
                    result_q <= alu_result;
                    zero_q   <= alu_zero;
`endif
                    state    <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_take)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter with a cycle-timing transaction model and a stub ALU.
`timescale 1ns/1ps
module tb_alu_arbiter;
    import alu_pkg::*;
    localparam int W = ALU_WIDTH;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n;
    logic req0_valid, req1_valid, req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_op, req1_op;
    logic rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [W-1:0] rsp_result;
    logic rsp_zero;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_control;
    logic alu_zero, busy;
`ifdef ALU_ARB_OP_CHECK_EN
    logic rsp_err;
`endif

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
`ifdef ALU_ARB_OP_CHECK_EN
        .rsp_err(rsp_err),
`endif
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .busy(busy)
    );

    // Stand-in for the external ALU; unknown opcodes behave as add.
    always_comb begin
        case (alu_control)
            3'b001:  alu_result = alu_a - alu_b;
            3'b011:  alu_result = (alu_b < 16'(W)) ? (alu_a << alu_b) : '0;
            default: alu_result = alu_a + alu_b;
        endcase
        alu_zero = (alu_result == '0);
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    a_req0_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (req0_valid && !req0_ready) |=> (req0_valid && $stable({req0_a, req0_b, req0_op})));
    a_req1_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (req1_valid && !req1_ready) |=> (req1_valid && $stable({req1_a, req1_b, req1_op})));

    // Reference arithmetic: plain modular integer math.
    function automatic logic is_legal(input logic [2:0] op);
        return (op == 3'd0) || (op == 3'd1) || (op == 3'd3);
    endfunction

    function automatic logic [W-1:0] ref_res(input txn_t t);
        longint unsigned m = 64'd1 << W;
        longint unsigned a = 64'(t.a);
        longint unsigned b = 64'(t.b);
        case (t.op)
            3'd1:    return W'((a + m - b) % m);
            3'd3:    return (b >= 64'(W)) ? '0 : W'((a * (64'd1 << b)) % m);
            default: return W'((a + b) % m);
        endcase
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        int k = $urandom_range(0, 9);
        int v;
        t.a = W'($urandom);
        t.b = W'($urandom);
        if (k < 3)      t.op = ALU_OP_ADD;
        else if (k < 6) t.op = ALU_OP_SUB;
        else if (k < 9) t.op = ALU_OP_SLL;
        else begin
            v = $urandom_range(0, 4);
            t.op = (v == 0) ? 3'd2 : 3'(v + 3);
        end
        if (t.op == ALU_OP_SLL) t.b = W'($urandom_range(0, 19));
        if (t.op == ALU_OP_SUB && $urandom_range(0, 3) == 0) t.b = t.a;
        return t;
    endfunction

    // Requester side
    txn_t cur [2];
    bit   cur_vld [2];
    txn_t dq0 [$];
    txn_t dq1 [$];
    bit   force_both;
    int   hold_cnt;

    // Model: an op accepted in cycle c owns the block; ALU cycle c+1; response from c+2 until taken.
    int   cyc;
    bit   inflight;
    int   acc_cyc;
    int   own;
    int   last;
    txn_t m_t;
    int   done [2];
    bit   rst_pending;

    task automatic drive();
        req0_valid = cur_vld[0]; req0_a = cur[0].a; req0_b = cur[0].b; req0_op = cur[0].op;
        req1_valid = cur_vld[1]; req1_a = cur[1].a; req1_b = cur[1].b; req1_op = cur[1].op;
    endtask

    task automatic check_reset_outputs(input string where);
        chk_eq({where, "_rsp0_valid"}, 32'(rsp0_valid), 0);
        chk_eq({where, "_rsp1_valid"}, 32'(rsp1_valid), 0);
        chk_eq({where, "_rsp_result"}, 32'(rsp_result), 0);
        chk_eq({where, "_rsp_zero"},   32'(rsp_zero), 0);
`ifdef ALU_ARB_OP_CHECK_EN
        chk_eq({where, "_rsp_err"},    32'(rsp_err), 0);
`endif
        chk_eq({where, "_alu_ab"},     {alu_a, alu_b}, 0);
        chk_eq({where, "_alu_control"}, 32'(alu_control), 0);
        chk_eq({where, "_busy"},       32'(busy), 0);
        chk_eq({where, "_req_ready"},  {30'd0, req1_ready, req0_ready}, 0);
    endtask

    task automatic step(input int p_valid, input int p_ready);
        int w;
        bit rsp_phase;
        logic [W-1:0] e_res;
        logic e_zero, e_err;
        logic [2:0] e_ctl;
        @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            if (!cur_vld[r] && (force_both || $urandom_range(0, 99) < p_valid)) begin
                if (r == 0 && dq0.size() > 0)      cur[r] = dq0.pop_front();
                else if (r == 1 && dq1.size() > 0) cur[r] = dq1.pop_front();
                else                               cur[r] = rand_txn();
                cur_vld[r] = 1'b1;
            end
        end
        force_both = 1'b0;
        drive();
        if (hold_cnt > 0) begin
            hold_cnt--;
            rsp0_ready = 1'b0;
            rsp1_ready = 1'b0;
        end else begin
            rsp0_ready = ($urandom_range(0, 99) < p_ready);
            rsp1_ready = ($urandom_range(0, 99) < p_ready);
        end
        #1;
        w = -1;
        if (!inflight) begin
            if (cur_vld[0] && cur_vld[1]) w = (last == 0) ? 1 : 0;
            else if (cur_vld[0])          w = 0;
            else if (cur_vld[1])          w = 1;
        end
        rsp_phase = inflight && (cyc >= acc_cyc + 2);
        chk_eq("req0_ready", 32'(req0_ready), 32'(w == 0));
        chk_eq("req1_ready", 32'(req1_ready), 32'(w == 1));
        chk_eq("busy", 32'(busy), 32'(inflight));
        chk_eq("rsp0_valid", 32'(rsp0_valid), 32'(rsp_phase && own == 0));
        chk_eq("rsp1_valid", 32'(rsp1_valid), 32'(rsp_phase && own == 1));

        e_res  = ref_res(m_t);
        e_zero = (e_res == '0);
        e_err  = 1'b0;
        e_ctl  = m_t.op;
`ifdef ALU_ARB_OP_CHECK_EN
        if (!is_legal(m_t.op)) begin
            e_res = '0; e_zero = 1'b0; e_err = 1'b1; e_ctl = 3'd0;
        end
`endif
        if (inflight && cyc == acc_cyc + 1) begin
            chk_eq("alu_a", 32'(alu_a), 32'(m_t.a));
            chk_eq("alu_b", 32'(alu_b), 32'(m_t.b));
            chk_eq("alu_control", 32'(alu_control), 32'(e_ctl));
        end
        if (rsp_phase) begin
            chk_eq("rsp_result", 32'(rsp_result), 32'(e_res));
            chk_eq("rsp_zero", 32'(rsp_zero), 32'(e_zero));
`ifdef ALU_ARB_OP_CHECK_EN
            chk_eq("rsp_err", 32'(rsp_err), 32'(e_err));
`endif
        end

        if (rst_pending && inflight && cyc == acc_cyc + 1) begin
            cur_vld[0] = 1'b0;
            cur_vld[1] = 1'b0;
            drive();
            rst_n = 1'b0;
            #1;
            check_reset_outputs("midrst");
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            inflight = 1'b0; last = 1; rst_pending = 1'b0;
            force_both = 1'b1; hold_cnt = 0;
            cyc++;
            return;
        end

        if (w >= 0) begin
            inflight = 1'b1; acc_cyc = cyc; own = w; last = w;
            m_t = cur[w];
            cur_vld[w] = 1'b0;
            if ($urandom_range(0, 3) == 0) hold_cnt = 6;
        end else if (rsp_phase && ((own == 0) ? rsp0_ready : rsp1_ready)) begin
            inflight = 1'b0;
            done[own]++;
        end
        cyc++;
    endtask

    initial begin
        rst_n = 1'b0;
        cur_vld[0] = 1'b0; cur_vld[1] = 1'b0;
        cur[0] = '0; cur[1] = '0;
        drive();
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        cyc = 0; inflight = 1'b0; acc_cyc = 0; own = 0; last = 1;
        m_t = '0; done[0] = 0; done[1] = 0;
        force_both = 1'b0; hold_cnt = 0; rst_pending = 1'b0;

        dq0.push_back('{a: 16'h0003, b: 16'h0004, op: 3'b000});
        dq0.push_back('{a: 16'h0003, b: 16'h0004, op: 3'b111});
        dq1.push_back('{a: 16'h0005, b: 16'h0005, op: 3'b001});
        dq1.push_back('{a: 16'h0001, b: 16'h0004, op: 3'b011});

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 60; i++)  step(60, 70);
        for (int i = 0; i < 200; i++) step(100, 100);

        rst_pending = 1'b1;
        for (int i = 0; i < 100 && rst_pending; i++) step(80, 80);
        chk_eq("midrst_reached", 32'(rst_pending), 0);

        for (int i = 0; i < 1500; i++) step(50, 50);

        chk_eq("req0_served", 32'(done[0] > 20), 1);
        chk_eq("req1_served", 32'(done[1] > 20), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared 16-bit ALU. Each requester presents operands and a 3-bit opcode over a valid/ready handshake. The block grants round-robin, registers the operands, drives the ALU for one cycle, captures result and zero flag, and returns them on a per-requester response handshake. It sits between the instruction-issue/address-generation units and the single combinational ALU instance.

## Interface
- `WIDTH`, default 16: operand/result width; must match the ALU.
- `clk`  in  1  rising-edge clock; one clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`, `req1_valid`  in  1  request present.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  WIDTH  operands.
- `req0_op`, `req1_op`  in  3  opcode: 000 add, 001 sub, 011 shift-left a by b.
- `rsp0_valid`, `rsp1_valid`  out  1  response present.
- `rsp0_ready`, `rsp1_ready`  in  1  requester takes the response.
- `rsp_result`  out  WIDTH  result; shared by both requesters, qualified by `rspN_valid`.
- `rsp_zero`  out  1  result == 0.
- `rsp_err`  out  1  illegal opcode. Present only with `ALU_ARB_OP_CHECK_EN`.
- `alu_a`, `alu_b`  out  WIDTH  ALU operands, driven straight from the operand registers.
- `alu_control`  out  3  ALU opcode, driven from the opcode register.
- `alu_result`  in  WIDTH  ALU result.
- `alu_zero`  in  1  ALU zero flag.
- `busy`  out  1  state != IDLE.

## Operation
- FSM states: IDLE → ISSUE → RESP → IDLE.
- **IDLE**
  - Arbitrate among the asserted `reqN_valid`.
  - If only one is valid, it wins.
  - If both are valid, the requester not equal to `last_grant` wins.
  - `reqN_ready` is combinational: 1 only for the winner, and only in IDLE.
  - On handshake: latch a, b, op and the owner id, update `last_grant`, go to ISSUE.
- **ISSUE**
  - The ALU sees the registered operands.
  - Latch `alu_result` and `alu_zero` into the response registers, go to RESP.
- **RESP**
  - `rspN_valid` = 1 for the owner only.
  - Result and zero hold stable until `rspN_ready` = 1 for the owner; then go to IDLE.
  - `rspN_ready` from the non-owner is ignored.
- Requester rules:
  - `reqN_valid` and its payload must stay stable until `reqN_ready`.
  - The bench checks this with assertions; the block does not.
- No arithmetic is done in this block. Widths pass through unchanged; overflow and shift wrap are the ALU's behaviour.
- Reset values:
  - state = IDLE, `last_grant` = 1 (so requester 0 wins first).
  - All `rsp*` outputs = 0.
  - `alu_a` = `alu_b` = 0, `alu_control` = 000, `busy` = 0, `reqN_ready` = 0.
- Reset mid-operation (any state): the in-flight operation is discarded and no response is produced.

## Timing
- Request handshake in cycle 0 → ALU driven in cycle 1 → `rspN_valid` high from cycle 2.
- Minimum occupancy is 3 cycles per operation. Peak throughput is one op per 3 cycles.
- Each cycle of response backpressure adds one cycle of occupancy.
- If a request and a pending response would coincide, the next request can be accepted no earlier than the cycle after the response handshake.
- `reqN_ready` depends combinationally on `reqN_valid`, state and `last_grant`. No combinational path from `rsp*_ready` to `req*_ready`.
- Round-robin fairness: with both requesters continuously valid, grants strictly alternate.

## Configuration
- Macro: `ALU_ARB_OP_CHECK_EN`.
- Defined:
  - Opcodes 010, 100–111 are illegal.
  - ISSUE still takes one cycle, but `alu_control` is forced to 000.
  - The response is `rsp_result` = 0, `rsp_zero` = 0, `rsp_err` = 1.
  - `rsp_err` = 0 for legal opcodes.
- Undefined:
  - The `rsp_err` port does not exist.
  - The opcode is forwarded unchanged, so the ALU's default (add) applies.

## Structure
- Package `alu_pkg` holds:
  - opcode constants `ALU_OP_ADD` = 000, `ALU_OP_SUB` = 001, `ALU_OP_SLL` = 011;
  - `ALU_WIDTH` = 16;
  - the FSM state enum `alu_arb_state_t`.
- One sub-module, `rr_arb2`: combinational 2-way round-robin grant from the two valid signals and `last_grant`. It outputs a one-hot grant.
- The ALU itself is instantiated outside, beside this block.

## Test plan
- Add: req0 a=0x0003, b=0x0004, op=000 → `rsp0_valid` in cycle 2, `rsp_result`=0x0007, `rsp_zero`=0; `rsp1_valid` stays 0.
- Sub and shift:
  - req1 a=0x0005, b=0x0005, op=001 → 0x0000, `rsp_zero`=1.
  - Then req1 a=0x0001, b=0x0004, op=011 → 0x0010.
- Arbitration: both requesters continuously valid from reset, 4 ops each → grant order 0,1,0,1…; no starvation; each response matches its own operands.
- Backpressure: hold `rsp0_ready`=0 for 5 cycles → `rsp0_valid`, `rsp_result` and `rsp_zero` stable throughout; `req*_ready`=0 until the cycle after the handshake.
- Illegal op 111 with a=0x0003, b=0x0004:
  - With macro → `rsp_err`=1, `rsp_result`=0.
  - Without macro → `rsp_result`=0x0007.
- Reset: assert `rst_n`=0 during ISSUE → all outputs return to reset values immediately; no response issued after release; next request from req0 is granted first.
